// File: rtl/alu_digit_serial.sv
// alu_digit_serial
//   Digit-serial ALU. Operands of WIDTH bits are consumed DIGIT bits per clock,
//   least significant digit first, through one shared digit datapath. The
//   carry between digits is held in a register. A request is taken with a
//   valid/ready handshake. The result and flags are registered and held until
//   the downstream side accepts them.
//
//   Parameters
//     WIDTH : operand/result width. Must be a multiple of DIGIT and >= 2*DIGIT.
//     DIGIT : bits processed per clock (1, 2 or 4).
//
//   Optional build macro
//     ALU_DIGIT_SERIAL_OVERFLOW_EN : adds tx_overflowflag, the signed overflow
//                                    flag for ADD/SUB.
//
//   Ports
//     rx_clk, rx_reset  : clock and synchronous active-high reset
//     rx_valid/tx_ready : request handshake; tx_ready is high only in IDLE
//     rx_what_op        : 000 ADD, 001 SUB, 010 ROL, 011 AND, 100 ORR,
//                         101 EOR, 110/111 illegal
//     rx_carryflag      : carry/borrow-in for ADD/SUB/ROL
//     rx_operand0/1     : operands A and B
//     tx_valid/rx_ready : result handshake
//     tx_result         : result
//     tx_carryflag      : carry (ADD/ROL), borrow (SUB), 0 for logic ops
//     tx_zeroflag       : result == 0
//     tx_signflag       : result MSB
//     tx_error          : the last accepted opcode was illegal
//
//   state | meaning
//   IDLE  | ready for a request; the previous result and flags are still visible
//   RUN   | one digit processed per cycle, N = WIDTH/DIGIT cycles
//   DONE  | result valid, held until rx_ready

module alu_digit_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             rx_clk,
  input  logic             rx_reset,
  input  logic             rx_valid,
  output logic             tx_ready,
  input  logic [2:0]       rx_what_op,
  input  logic             rx_carryflag,
  input  logic [WIDTH-1:0] rx_operand0,
  input  logic [WIDTH-1:0] rx_operand1,
  output logic             tx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] tx_result,
  output logic             tx_carryflag,
  output logic             tx_zeroflag,
  output logic             tx_signflag,
  output logic             tx_error
`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
  ,
  output logic             tx_overflowflag
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ROL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_ORR = 3'b100;
  localparam logic [2:0] OP_EOR = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             carry_flag_q, zero_flag_q, sign_flag_q, error_q;

  logic [DIGIT-1:0] a_d, b_d, b_eff, s_d;
  logic [DIGIT:0]   sum_d;
  logic [DIGIT:0]   rol_d;
  logic             c_out;
  logic [WIDTH-1:0] res_next;
  logic             last_digit;
  logic             op_legal;
  logic             final_carry;

`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
  logic ovf_flag_q;
  logic c_into_msb;
  logic ovf_d;
`endif

  assign op_legal = (rx_what_op <= OP_EOR);

  // The operand registers shift right by one digit per RUN cycle, so the
  // digit selected by the counter always sits in the low DIGIT bits.
  assign a_d = a_q[DIGIT-1:0];
  assign b_d = b_q[DIGIT-1:0];

  // Subtraction runs as A + ~B + carry, where the chained carry is the
  // inverted borrow.
  assign b_eff = (op_q == OP_SUB) ? ~b_d : b_d;
  assign sum_d = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT{1'b0}}, c_q};

  // For ROL the chained "carry" is the top bit of the previous digit of A.
  // For the first digit it is the carry-in.
  assign rol_d = {a_d, c_q};

  always_comb begin
    s_d   = '0;
    c_out = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        s_d   = sum_d[DIGIT-1:0];
        c_out = sum_d[DIGIT];
      end
      OP_ROL: begin
        s_d   = rol_d[DIGIT-1:0];
        c_out = a_d[DIGIT-1];
      end
      OP_AND: s_d = a_d & b_d;
      OP_ORR: s_d = a_d | b_d;
      OP_EOR: s_d = a_d ^ b_d;
      default: begin
        s_d   = '0;
        c_out = 1'b0;
      end
    endcase
  end

  // New digits enter at the top. After N shifts, every digit is in place.
  assign res_next   = {s_d, res_q[WIDTH-1:DIGIT]};
  assign last_digit = (cnt_q == CW'(N - 1));

  always_comb begin
    final_carry = 1'b0;
    case (op_q)
      OP_ADD, OP_ROL: final_carry = c_out;
      OP_SUB:         final_carry = ~c_out;
      default:        final_carry = 1'b0;
    endcase
  end

`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
  // Signed overflow is the XOR of the carries into and out of the result MSB.
  // These are only meaningful on the final digit.
  assign c_into_msb = a_d[DIGIT-1] ^ b_eff[DIGIT-1] ^ s_d[DIGIT-1];
  assign ovf_d      = ((op_q == OP_ADD) || (op_q == OP_SUB)) && (c_into_msb ^ c_out);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rx_valid) state_d = op_legal ? RUN : DONE;
      RUN:  if (last_digit) state_d = DONE;
      DONE: if (rx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      c_q          <= 1'b0;
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
      sign_flag_q  <= 1'b0;
      error_q      <= 1'b0;
`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
      ovf_flag_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            op_q         <= rx_what_op;
            a_q          <= rx_operand0;
            b_q          <= rx_operand1;
            res_q        <= '0;
            cnt_q        <= '0;
            // The carry register holds the inverted borrow for SUB.
            c_q          <= (rx_what_op == OP_SUB) ? ~rx_carryflag : rx_carryflag;
            carry_flag_q <= 1'b0;
            sign_flag_q  <= 1'b0;
            error_q      <= ~op_legal;
            // An illegal opcode goes straight to DONE with a zero result.
            zero_flag_q  <= ~op_legal;
`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
            ovf_flag_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          res_q <= res_next;
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          c_q   <= c_out;
          cnt_q <= cnt_q + CW'(1);
          if (last_digit) begin
            carry_flag_q <= final_carry;
            zero_flag_q  <= (res_next == '0);
            sign_flag_q  <= res_next[WIDTH-1];
`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
            ovf_flag_q   <= ovf_d;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    tx_ready = 1'b0;
    tx_valid = 1'b0;
    case (state_q)
      IDLE:    tx_ready = 1'b1;
      DONE:    tx_valid = 1'b1;
      default: begin
      end
    endcase
  end

  assign tx_result    = res_q;
  assign tx_carryflag = carry_flag_q;
  assign tx_zeroflag  = zero_flag_q;
  assign tx_signflag  = sign_flag_q;
  assign tx_error     = error_q;
`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
  assign tx_overflowflag = ovf_flag_q;
`endif

endmodule

// File: tb/tb_alu_digit_serial.sv
// Self-checking bench for alu_digit_serial (WIDTH=8, DIGIT=2).
// Expected values come from a whole-word arithmetic model.
module tb_alu_digit_serial;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

  logic         rx_clk = 1'b0;
  logic         rx_reset;
  logic         rx_valid;
  logic         tx_ready;
  logic [2:0]   rx_what_op;
  logic         rx_carryflag;
  logic [W-1:0] rx_operand0, rx_operand1;
  logic         tx_valid;
  logic         rx_ready;
  logic [W-1:0] tx_result;
  logic         tx_carryflag, tx_zeroflag, tx_signflag, tx_error;
`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
  logic         tx_overflowflag;
`endif

  int checks = 0;
  int errors = 0;

  alu_digit_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .rx_clk       (rx_clk),
    .rx_reset     (rx_reset),
    .rx_valid     (rx_valid),
    .tx_ready     (tx_ready),
    .rx_what_op   (rx_what_op),
    .rx_carryflag (rx_carryflag),
    .rx_operand0  (rx_operand0),
    .rx_operand1  (rx_operand1),
    .tx_valid     (tx_valid),
    .rx_ready     (rx_ready),
    .tx_result    (tx_result),
    .tx_carryflag (tx_carryflag),
    .tx_zeroflag  (tx_zeroflag),
    .tx_signflag  (tx_signflag),
    .tx_error     (tx_error)
`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
    ,
    .tx_overflowflag (tx_overflowflag)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  // Whole-word reference model.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, output logic [W-1:0] r, output logic c,
                                output logic e, output logic v);
    int s;
    r = '0; c = 1'b0; e = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b) + int'(cin);
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: begin
        s = int'(a) - int'(b) - int'(cin);
        r = s[W-1:0];
        c = int'(a) < (int'(b) + int'(cin));
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd2: begin
        r = {a[W-2:0], cin};
        c = a[W-1];
      end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      default: e = 1'b1;
    endcase
  endfunction

  // Issue one op at a negedge and wait for tx_valid. Then check latency,
  // result and flags while the block sits in DONE.
  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin);
    logic [W-1:0] er;
    logic ec, ee, ev;
    int n, lat, exp_lat;
    model(op, a, b, cin, er, ec, ee, ev);
    exp_lat = ee ? 1 : N + 1;
    n = 0;
    while (!tx_ready && n < 20) begin @(negedge rx_clk); n++; end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_timeout got %b want 1", name, tx_ready);
    end
    rx_what_op = op; rx_operand0 = a; rx_operand1 = b; rx_carryflag = cin; rx_valid = 1'b1;
    @(negedge rx_clk);
    rx_valid = 1'b0;
    rx_what_op = 3'($urandom); rx_operand0 = W'($urandom); rx_operand1 = W'($urandom);
    rx_carryflag = 1'($urandom);
    lat = 1;
    while (!tx_valid && lat < 20) begin @(negedge rx_clk); lat++; end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (tx_result !== er) begin
      errors++; $display("FAIL %s result got %h want %h", name, tx_result, er);
    end
    checks++;
    if ({tx_carryflag, tx_zeroflag, tx_signflag, tx_error} !== {ec, (er == '0), er[W-1], ee}) begin
      errors++;
      $display("FAIL %s flags(c,z,s,e) got %b%b%b%b want %b%b%b%b", name, tx_carryflag,
               tx_zeroflag, tx_signflag, tx_error, ec, (er == '0), er[W-1], ee);
    end
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL %s ready_in_done got %b want 0", name, tx_ready);
    end
`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
    checks++;
    if (tx_overflowflag !== ev) begin
      errors++; $display("FAIL %s overflow got %b want %b", name, tx_overflowflag, ev);
    end
`endif
    if (rx_ready) @(negedge rx_clk);
  endtask

  task automatic test_reset;
    rx_reset = 1'b1; rx_valid = 1'b0; rx_ready = 1'b1;
    rx_what_op = '0; rx_operand0 = '0; rx_operand1 = '0; rx_carryflag = 1'b0;
    repeat (3) @(negedge rx_clk);
    rx_reset = 1'b0;
    checks++;
    if ({tx_valid, tx_result, tx_carryflag, tx_zeroflag, tx_signflag, tx_error, tx_ready}
        !== {1'b0, {W{1'b0}}, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL reset outputs got v=%b r=%h c=%b z=%b s=%b e=%b rdy=%b want all 0 rdy=1",
               tx_valid, tx_result, tx_carryflag, tx_zeroflag, tx_signflag, tx_error, tx_ready);
    end
  endtask

  task automatic test_directed;
    do_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 1'b0);
    do_op("sub_10_20", 3'd1, 8'h10, 8'h20, 1'b0);
    do_op("sub_20_10_c", 3'd1, 8'h20, 8'h10, 1'b1);
    do_op("rol_81", 3'd2, 8'h81, 8'h5A, 1'b1);
    do_op("eor_aa", 3'd5, 8'hAA, 8'hAA, 1'b0);
    do_op("and_f0_3c", 3'd3, 8'hF0, 8'h3C, 1'b1);
    do_op("orr_0f_30", 3'd4, 8'h0F, 8'h30, 1'b1);
  endtask

  task automatic test_illegal;
    do_op("illegal_110", 3'b110, 8'h12, 8'h34, 1'b1);
    do_op("illegal_111", 3'b111, 8'hFF, 8'hFF, 1'b0);
    do_op("legal_after_illegal", 3'd0, 8'h01, 8'h01, 1'b0);
  endtask

  task automatic test_backpressure;
    rx_ready = 1'b0;
    do_op("bp_add", 3'd0, 8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge rx_clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_result !== 8'h46 || tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b r=%h rdy=%b want v=1 r=46 rdy=0",
                 i, tx_valid, tx_result, tx_ready);
      end
    end
    rx_ready = 1'b1;
    @(negedge rx_clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", tx_valid, tx_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    rx_what_op = 3'd0; rx_operand0 = 8'h12; rx_operand1 = 8'h34; rx_carryflag = 1'b0;
    rx_valid = 1'b1;
    @(negedge rx_clk);
    rx_valid = 1'b0;
    @(negedge rx_clk);
    rx_reset = 1'b1;
    @(negedge rx_clk);
    rx_reset = 1'b0;
    checks++;
    if ({tx_valid, tx_result, tx_carryflag, tx_zeroflag, tx_signflag, tx_error, tx_ready}
        !== {1'b0, {W{1'b0}}, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL midrun_reset got v=%b r=%h c=%b z=%b s=%b e=%b rdy=%b want all 0 rdy=1",
               tx_valid, tx_result, tx_carryflag, tx_zeroflag, tx_signflag, tx_error, tx_ready);
    end
    for (int i = 0; i < N + 2; i++) begin
      @(negedge rx_clk);
      checks++;
      if (tx_valid !== 1'b0) begin
        errors++; $display("FAIL midrun_no_result cycle %0d got v=%b want 0", i, tx_valid);
      end
    end
    do_op("and_after_reset", 3'd3, 8'hF0, 8'h3C, 1'b0);
`ifdef ALU_DIGIT_SERIAL_OVERFLOW_EN
    do_op("ovf_add_7f_01", 3'd0, 8'h7F, 8'h01, 1'b0);
    do_op("ovf_sub_80_01", 3'd1, 8'h80, 8'h01, 1'b0);
`endif
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      do_op("random", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom));
  endtask

  // rx_valid and rx_ready are held high. A result must appear every N+2 cycles.
  task automatic test_back_to_back;
    logic [W-1:0] q_r[$];
    logic         q_c[$];
    logic [W-1:0] er, ea, eb;
    logic ec, ee, ev, cin;
    logic [2:0] op;
    int sent, got, cyc, last;
    sent = 0; got = 0; cyc = 0; last = -1;
    rx_ready = 1'b1;
    while (got < 6 && cyc < 200) begin
      if (tx_valid) begin
        if (q_r.size() > 0) begin
          er = q_r.pop_front(); ec = q_c.pop_front();
          checks++;
          if (tx_result !== er || tx_carryflag !== ec) begin
            errors++;
            $display("FAIL b2b result got %h/%b want %h/%b", tx_result, tx_carryflag, er, ec);
          end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != N + 2) begin
            errors++; $display("FAIL b2b interval got %0d want %0d", cyc - last, N + 2);
          end
        end
        last = cyc;
        got++;
      end
      if (tx_ready) begin
        if (sent < 6) begin
          op = 3'($urandom_range(0, 5)); ea = W'($urandom); eb = W'($urandom); cin = 1'($urandom);
          model(op, ea, eb, cin, er, ec, ee, ev);
          q_r.push_back(er); q_c.push_back(ec);
          rx_what_op = op; rx_operand0 = ea; rx_operand1 = eb; rx_carryflag = cin;
          rx_valid = 1'b1;
          sent++;
        end else begin
          rx_valid = 1'b0;
        end
      end
      @(negedge rx_clk);
      cyc++;
    end
    rx_valid = 1'b0;
    checks++;
    if (got != 6) begin
      errors++; $display("FAIL b2b timeout got %0d results want 6", got);
    end
  endtask

  initial begin
    rx_reset = 1'b1;
    rx_valid = 1'b0;
    rx_ready = 1'b1;
    @(negedge rx_clk);
    test_reset();
    test_directed();
    test_illegal();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_digit_serial.md
Name: alu_digit_serial

Overview:
- Parametrised digit-serial successor to the 2-bit LUT ALU slice.
- Processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, through one shared digit datapath; carry is chained between digits in a register.
- Adds a valid/ready handshake, a run-length counter, registered result and flags, and illegal-opcode detection.
- Sits between the register-file read stage and writeback in area-constrained FPGA cores.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT and >= 2*DIGIT.
- DIGIT, 2, bits processed per cycle; legal values 1, 2, 4.

Ports:
- rx_clk  input  1  clock; all logic rising-edge.
- rx_reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  request valid.
- tx_ready  output  1  block can accept a request; high only in IDLE.
- rx_what_op  input  3  opcode: 000 ADD, 001 SUB, 010 ROL, 011 AND, 100 ORR, 101 EOR, 110/111 illegal.
- rx_carryflag  input  1  carry/borrow-in for ADD/SUB/ROL; ignored by logic ops.
- rx_operand0  input  WIDTH  operand A.
- rx_operand1  input  WIDTH  operand B; ignored by ROL.
- tx_valid  output  1  result valid.
- rx_ready  input  1  downstream accepts result.
- tx_result  output  WIDTH  result.
- tx_carryflag  output  1  carry-out (ADD/ROL), borrow-out (SUB), 0 for logic ops.
- tx_zeroflag  output  1  tx_result == 0.
- tx_signflag  output  1  tx_result[WIDTH-1].
- tx_error  output  1  illegal opcode latched.

Behaviour:
- Reset: state IDLE; tx_valid, tx_result, tx_carryflag, tx_zeroflag, tx_signflag and tx_error all 0; digit counter 0. Reset mid-RUN or mid-DONE abandons the operation; no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE: tx_ready = 1. On rx_valid = 1:
  - Latch opcode, A, B and carry-in; clear the result shift register and counter.
  - Legal opcode: go to RUN.
  - Illegal opcode: go straight to DONE with result 0, tx_carryflag 0, tx_error 1, tx_zeroflag 1.
- RUN: tx_ready = 0.
  - Each cycle, process digit k = counter: A[k*DIGIT +: DIGIT] and B[k*DIGIT +: DIGIT] with the chained carry.
  - Shift the result digit into the result register MSB-first so that result bits end in place; increment counter.
  - After digit N-1 (N = WIDTH/DIGIT), go to DONE. RUN lasts exactly N cycles.
- DONE: tx_valid = 1; tx_result and all flags stable.
  - On rx_ready = 1 in the same cycle: go to IDLE and drop tx_valid next cycle.
  - No request is accepted in the DONE cycle (tx_ready = 0).
- Latency: accept edge to tx_valid = N+1 cycles. Throughput: one op per N+2 cycles when rx_ready is held high.
- ADD: A + B + cin at full width; tx_carryflag = bit WIDTH of the sum.
- SUB: A - B - cin; tx_carryflag = 1 if A < B + cin (unsigned borrow). Each digit computes A_d + ~B_d + ~borrow, and borrow = ~carry.
- ROL: rotate left through carry by 1 bit. Result = {A[WIDTH-2:0], cin}; tx_carryflag = A[WIDTH-1]. Each digit takes the previous digit's top bit as its LSB.
- AND/ORR/EOR: bitwise; tx_carryflag = 0.
- Flags: zero and sign are computed from the final result and registered on entry to DONE.
- Inputs are sampled only at acceptance; changes while busy have no effect.

Optional Feature:
- Macro: ALU_DIGIT_SERIAL_OVERFLOW_EN.
- Defined:
  - Adds output port tx_overflowflag (1 bit), reset 0, valid in DONE.
  - ADD: set when A and B have the same sign and the result sign differs.
  - SUB: set when A and B have different signs and the result sign differs from A's.
  - 0 for all other ops and for illegal opcodes.
  - Derived from the carry into and out of the final digit's MSB.
- Undefined: the port is absent and no overflow logic is built; all other behaviour is identical.

Test Plan (WIDTH=8, DIGIT=2, rx_ready held high unless stated):
- ADD A=0xFF, B=0x01, cin=0 -> tx_valid 5 cycles after accept; result 0x00, carry 1, zero 1, sign 0, error 0.
- SUB A=0x10, B=0x20, cin=0 -> result 0xF0, carry (borrow) 1, sign 1, zero 0. Then SUB A=0x20, B=0x10, cin=1 -> result 0x0F, carry 0.
- ROL A=0x81, cin=1 -> result 0x03, carry 1. EOR A=0xAA, B=0xAA -> result 0x00, zero 1, carry 0.
- Illegal opcode 3'b110 -> tx_valid 1 cycle after accept; result 0x00, error 1, zero 1.
- Backpressure: ADD 0x12+0x34, rx_ready low for 5 cycles -> tx_valid and result 0x46 held stable; tx_ready 0 throughout. Raising rx_ready returns the block to IDLE one cycle later, and tx_ready goes to 1.
- Reset mid-RUN: assert rx_reset on the 2nd RUN cycle -> next cycle all outputs 0 and tx_ready 1; a following AND 0xF0&0x3C -> 0x30. With ALU_DIGIT_SERIAL_OVERFLOW_EN defined: ADD 0x7F+0x01 -> result 0x80, overflow 1.
